// File: rtl/tile_pkg.sv
// ---------------------------------------------------------------------------
// tile_pkg
//   Constants and types shared by the tile instruction fetch scheduler and
//   its round-robin arbiter.
//   - NUM_CORES : cores per tile; also the width of one-hot core selects
//   - ADDR_W    : instruction address width
//   - CHUNK     : instructions per block read (matches the memory block size)
//   - WEB_*     : bit positions inside the memory control word mem_web
//   - state_e   : scheduler FSM states
// ---------------------------------------------------------------------------
package tile_pkg;

  localparam int NUM_CORES = 16;
  localparam int ADDR_W    = 16;
  localparam int CHUNK     = 64;

  // Memory control word bit positions.
  localparam int WEB_HL     = 2;
  localparam int WEB_BLOCK  = 1;
  localparam int WEB_SINGLE = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    DELIVER = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter_16.sv
// ---------------------------------------------------------------------------
// rr_arbiter_16
//   Combinational round-robin pick. Returns the first asserted request at or
//   after rr_ptr, wrapping cyclically, so after a wrap the lowest index wins.
//   Ports:
//   - req       : request vector, one bit per core
//   - rr_ptr    : index where the search starts
//   - grant_idx : index of the selected request (0 when none)
//   - found     : at least one request was asserted
//   N must be a power of two: the candidate index wraps by natural overflow.
// ---------------------------------------------------------------------------
module rr_arbiter_16
  import tile_pkg::*;
#(
  parameter int N  = NUM_CORES,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] grant_idx,
  output logic          found
);

  logic [IW-1:0] cand_idx [N];
  logic [N-1:0]  hit;

  // hit[k] means the core k positions after rr_ptr is requesting.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign cand_idx[gi] = rr_ptr + IW'(gi);
    assign hit[gi]      = req[cand_idx[gi]];
  end

  // Scan from the furthest offset to the nearest so the nearest hit is the
  // last assignment and therefore wins.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        grant_idx = cand_idx[i];
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_ins_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// tile_ins_fetch_scheduler
//   Arbitrates the cores of a tile for block reads from the tile instruction
//   memory. Each core owns a fetch pointer and an inclusive end address; one
//   requesting core is picked round-robin, the memory block-output control is
//   driven for one cycle (ISSUE), and the core is told in the following cycle
//   (DELIVER) that its instruction bus holds the block.
//   Ports:
//   - clk, RST        : clock, asynchronous active-high reset
//   - cfg_we/core/start/end : load a program region for one core
//   - core_req        : per-core level request "ready for next block"
//   - mem_web         : memory control, only the block bit is ever set
//   - mem_start_addr  : block start address
//   - mem_end_addr    : region end address of the granted core
//   - mem_out_flag    : one-hot core select towards the memory
//   - core_valid      : one-cycle pulse, block present on the core's bus
//   - core_done       : sticky, region fully fetched
//   - busy            : FSM is not idle
// ---------------------------------------------------------------------------
module tile_ins_fetch_scheduler #(
  parameter  int NUM_CORES = tile_pkg::NUM_CORES,
  parameter  int ADDR_W    = tile_pkg::ADDR_W,
  parameter  int CHUNK     = tile_pkg::CHUNK,
  localparam int CORE_W    = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 cfg_we,
  input  logic [CORE_W-1:0]    cfg_core,
  input  logic [ADDR_W-1:0]    cfg_start,
  input  logic [ADDR_W-1:0]    cfg_end,
  input  logic [NUM_CORES-1:0] core_req,
  output logic [2:0]           mem_web,
  output logic [ADDR_W-1:0]    mem_start_addr,
  output logic [ADDR_W-1:0]    mem_end_addr,
  output logic [NUM_CORES-1:0] mem_out_flag,
  output logic [NUM_CORES-1:0] core_valid,
  output logic [NUM_CORES-1:0] core_done,
  output logic                 busy
);

  tile_pkg::state_e state_q, state_d;

  logic [CORE_W-1:0]    g_q, g_d;
  logic [CORE_W-1:0]    rr_q, rr_d;
  // Set when a cfg write hit the core of the in-flight block before DELIVER;
  // the reloaded pointer must not then be advanced.
  logic                 cfg_hit_q, cfg_hit_d;

  logic [2:0]           web_q, web_d;
  logic [ADDR_W-1:0]    start_q, start_d;
  logic [ADDR_W-1:0]    end_addr_q, end_addr_d;
  logic [NUM_CORES-1:0] flag_q, flag_d;
  logic [NUM_CORES-1:0] valid_q, valid_d;

  // Per-core state gathered for indexed reads.
  logic [ADDR_W:0]      ptr_all [NUM_CORES];
  logic [ADDR_W-1:0]    end_all [NUM_CORES];
  logic [NUM_CORES-1:0] en_all;
  logic [NUM_CORES-1:0] done_all;

  logic [NUM_CORES-1:0] eligible;
  logic [CORE_W-1:0]    arb_idx;
  logic                 arb_found;
  logic                 advance;
  logic [ADDR_W:0]      adv_ptr;

  assign eligible = core_req & en_all & ~done_all;
  assign advance  = (state_q == tile_pkg::DELIVER) && !cfg_hit_q;
  // One extra pointer bit keeps a region ending at the top address from
  // wrapping back to 0 and looking unfinished.
  assign adv_ptr  = ptr_all[g_q] + (ADDR_W + 1)'(CHUNK);

  rr_arbiter_16 #(
    .N  (NUM_CORES),
    .IW (CORE_W)
  ) u_arb (
    .req       (eligible),
    .rr_ptr    (rr_q),
    .grant_idx (arb_idx),
    .found     (arb_found)
  );

  // -------------------------------------------------------------------------
  // Per-core fetch state. A cfg write always wins over the DELIVER advance.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              en_q, en_d;
    logic              done_q, done_d;
    logic              cfg_sel;
    logic              adv_sel;

    assign cfg_sel = cfg_we && (cfg_core == CORE_W'(gi));
    assign adv_sel = advance && (g_q == CORE_W'(gi));

    always_comb begin
      ptr_d  = ptr_q;
      end_d  = end_q;
      en_d   = en_q;
      done_d = done_q;
      if (cfg_sel) begin
        ptr_d  = {1'b0, cfg_start};
        end_d  = cfg_end;
        en_d   = 1'b1;
        done_d = (cfg_start > cfg_end);
      end else if (adv_sel) begin
        ptr_d  = adv_ptr;
        done_d = (adv_ptr > {1'b0, end_q});
      end
    end

    always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
        ptr_q  <= '0;
        end_q  <= '0;
        en_q   <= 1'b0;
        done_q <= 1'b0;
      end else begin
        ptr_q  <= ptr_d;
        end_q  <= end_d;
        en_q   <= en_d;
        done_q <= done_d;
      end
    end

    assign ptr_all[gi]  = ptr_q;
    assign end_all[gi]  = end_q;
    assign en_all[gi]   = en_q;
    assign done_all[gi] = done_q;
  end

  // -------------------------------------------------------------------------
  // Scheduler FSM. Outputs are registered, so each value is computed in the
  // cycle before the state in which it must appear.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    rr_d       = rr_q;
    cfg_hit_d  = 1'b0;
    web_d      = '0;
    flag_d     = '0;
    valid_d    = '0;
    start_d    = start_q;
    end_addr_d = end_addr_q;

    unique case (state_q)
      tile_pkg::IDLE: begin
        if (arb_found) begin
          state_d    = tile_pkg::ISSUE;
          g_d        = arb_idx;
          web_d[tile_pkg::WEB_HL]     = 1'b0;
          web_d[tile_pkg::WEB_BLOCK]  = 1'b1;
          web_d[tile_pkg::WEB_SINGLE] = 1'b0;
          flag_d     = NUM_CORES'(1) << arb_idx;
          start_d    = ptr_all[arb_idx][ADDR_W-1:0];
          end_addr_d = end_all[arb_idx];
          // The address pair is already captured from the old region, so a
          // simultaneous reload of this core must survive the later advance.
          cfg_hit_d  = cfg_we && (cfg_core == arb_idx);
        end
      end
      tile_pkg::ISSUE: begin
        state_d   = tile_pkg::DELIVER;
        valid_d   = NUM_CORES'(1) << g_q;
        cfg_hit_d = cfg_hit_q || (cfg_we && (cfg_core == g_q));
      end
      tile_pkg::DELIVER: begin
        state_d = tile_pkg::IDLE;
        rr_d    = g_q + CORE_W'(1);
      end
      default: begin
        state_d = tile_pkg::IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= tile_pkg::IDLE;
      g_q        <= '0;
      rr_q       <= '0;
      cfg_hit_q  <= 1'b0;
      web_q      <= '0;
      start_q    <= '0;
      end_addr_q <= '0;
      flag_q     <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      rr_q       <= rr_d;
      cfg_hit_q  <= cfg_hit_d;
      web_q      <= web_d;
      start_q    <= start_d;
      end_addr_q <= end_addr_d;
      flag_q     <= flag_d;
      valid_q    <= valid_d;
    end
  end

  assign mem_web        = web_q;
  assign mem_start_addr = start_q;
  assign mem_end_addr   = end_addr_q;
  assign mem_out_flag   = flag_q;
  assign core_valid     = valid_q;
  assign core_done      = done_all;
  assign busy           = (state_q != tile_pkg::IDLE);

endmodule
